// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first, carry held in a flop.
// A result appears WIDTH+1 edges after start is accepted; sum/cout hold until the next result.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_c;

   // The single full-adder cell shared by every bit position.
   assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

   always_comb begin
      // NOTE: every *_d gets a default first so no path through this block infers a latch.
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = cin;
               cnt_d    = '0;
               sum_sh_d = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_c;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Visible result is only replaced here, so it never shows a partial sum.
               sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
               cout_d  = fa_c;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases plus random operations checked against
// plain integer addition, with latency, busy width, result hold and done counts.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a, b, sum;
   logic         cin, busy, done, cout;

   int           n_cmp = 0;
   int           n_err = 0;
   int           done_total = 0;
   logic [W:0]   last_res;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_total++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; returns at the falling edge where done is seen.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input int inj_at);
      int         edges, busy_n, hold_bad;
      logic [W:0] exp;
      exp = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
      edges = 1; busy_n = 0; hold_bad = 0;
      while (!done && edges < 4 * W) begin
         if (busy) busy_n++;
         if ({cout, sum} !== last_res) hold_bad++;
         if (edges == inj_at) begin
            start = 1'b1; a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      start = 1'b0;
      check({tag, "_latency"}, edges, W + 1);
      check({tag, "_busy_cycles"}, busy_n, W);
      check({tag, "_hold"}, hold_bad, 0);
      check({tag, "_result"}, {cout, sum}, exp);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      last_res = exp;
   endtask

   initial begin
      int snap, last_i, ndone, unstable, gap, inj;
      logic [W-1:0] ra, rb;
      logic         rc;

      // Reset state
      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      last_res = '0;

      // Directed operations
      run_op("d0f01", 8'h0F, 8'h01, 1'b0, 0);
      @(negedge clk); check("d0f01_done_pulse", done, 0);
      run_op("dff01", 8'hFF, 8'h01, 1'b0, 0);
      @(negedge clk); check("dff01_done_pulse", done, 0);
      run_op("dffff", 8'hFF, 8'hFF, 1'b1, 0);
      @(negedge clk); check("dffff_done_pulse", done, 0);

      // Start during SHIFT is ignored; no extra done afterwards
      run_op("dmid", 8'h12, 8'h34, 1'b0, 4);
      #1 snap = done_total;
      repeat (12) @(negedge clk);
      #1 check("dmid_extra_done", done_total - snap, 0);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_sum", sum, 0);
      check("arst_cout", cout, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      snap = done_total;
      repeat (15) @(negedge clk);
      #1;
      check("arst_no_done", done_total - snap, 0);
      check("arst_sum_after", {cout, sum}, 0);
      last_res = '0;

      // Continuous start: a result every W+1 cycles
      @(negedge clk);
      a = 8'h01; b = 8'h02; cin = 1'b1; start = 1'b1;
      last_i = -1; ndone = 0; unstable = 0;
      for (int i = 1; i <= 5 * (W + 1); i++) begin
         @(negedge clk);
         if (done) begin
            check("cont_result", {cout, sum}, 9'h004);
            if (last_i >= 0) check("cont_period", i - last_i, W + 1);
            last_i = i;
            ndone++;
         end else if (last_i >= 0 && {cout, sum} !== 9'h004) begin
            unstable++;
         end
      end
      start = 1'b0;
      check("cont_count", ndone, 5);
      check("cont_stable", unstable, 0);
      last_res = 9'h004;
      @(negedge clk);
      #1 check("cont_idle", done, 0);
      snap = done_total;

      // Random operations with random gaps and ignored mid-operation starts
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom()); rb = W'($urandom()); rc = 1'($urandom());
         gap = $urandom_range(0, 3);
         inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0;
         run_op("rnd", ra, rb, rc, inj);
         if (gap > 0) begin
            @(negedge clk);
            check("rnd_done_pulse", done, 0);
            repeat (gap - 1) @(negedge clk);
         end
      end
      #1 check("rnd_done_count", done_total - snap, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder built around a single one-bit full-adder cell (a, b, cin -> s, cout).
- Latches two N-bit operands and feeds the cell one bit pair per clock, LSB first, with the carry registered between cycles.
- Collects sum bits into an output register.
- Provides the sequencing stage that drives the full-adder cell; trades latency for area against a ripple-carry adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a new addition; sampled on rising clk edges
- a  input  WIDTH  operand A; sampled only on the edge that accepts start
- b  input  WIDTH  operand B; sampled only on the edge that accepts start
- cin  input  1  carry-in; sampled only on the edge that accepts start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle
- sum  output  WIDTH  registered result; holds the last completed result
- cout  output  1  registered carry-out of the MSB; holds with sum

Behaviour:
- Reset and clocking:
  - One clock domain; reset is asynchronous and active-low, ports clk and reset_n.
  - While reset_n=0: state=IDLE; operand shift registers, sum shift register, carry register and bit counter all 0; sum=0, cout=0, busy=0, done=0.
  - Reset deasserts cleanly at any point; an operation interrupted by reset is discarded with no partial result visible.
- Datapath:
  - The cell inputs are a_sh[0], b_sh[0] and carry_q.
  - Each SHIFT cycle:
    - a_sh and b_sh shift right by 1, zero-filled.
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
    - carry_q <= cell cout.
    - cnt <= cnt+1.
  - cnt is a $clog2(WIDTH)-bit counter.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0.
    - start=1 -> load a_sh=a, b_sh=b, carry_q=cin, cnt=0, sum_sh=0; go to SHIFT.
  - SHIFT: busy=1.
    - Process one bit per edge.
    - On the edge where cnt==WIDTH-1, the final bit is processed. On that same edge: sum <= {s, sum_sh[WIDTH-1:1]} and cout <= cell cout; go to DONE.
  - DONE: done=1, busy=0, for exactly one cycle.
    - start=1 -> accepted exactly as in IDLE (back-to-back operation, go to SHIFT).
    - Otherwise go to IDLE.
- Latency:
  - The start-accept edge is E0; the SHIFT edges are E1..EWIDTH.
  - done is high in the cycle following EWIDTH.
  - Total is WIDTH+1 edges from accept to result; throughput is one result per WIDTH+1 cycles with continuous start.
- Result stability:
  - sum and cout change only on the final SHIFT edge.
  - During an operation they hold the previous result; they hold indefinitely after done.
- start while in SHIFT is ignored. The operation is not restarted and the new request is not queued; a, b and cin changes mid-operation have no effect.
- Arithmetic: {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1); no saturation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (WIDTH=8):
- Reset, then a=8'h0F, b=8'h01, cin=0, start pulse -> done exactly 9 edges after the accept edge; sum=8'h10, cout=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple). Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start accepted with a=8'h12, b=8'h34. Mid-operation (cycle 4), pulse start with a=8'hAA, b=8'h55 -> ignored; result is sum=8'h46, cout=0; exactly one done pulse.
- Drive reset_n low in cycle 5 of an operation (a=8'h80, b=8'h80), with prior result sum=8'h46 -> sum=0, cout=0, busy=0, done=0 immediately and asynchronously. After release, no done occurs without a new start.
- Hold start=1 continuously with a=8'h01, b=8'h02, cin=1 -> done every 9 cycles, each time sum=8'h04, cout=0. sum stays stable between done pulses.
- Randomised 1000 operations with random a, b, cin and random idle gaps -> {cout, sum} matches a reference model; done count equals accepted starts.
